// File: rtl/ntt_intt_pkg.sv
// Shared types and helpers for the NTT/INTT load and control path.
// Bit-reversed bank addressing (INTT_LOAD_BITREV_EN) uses bitrev9 from here.
package ntt_intt_pkg;

  localparam int unsigned LANES   = 4;
  localparam int unsigned BANK_AW = 9;
  localparam int unsigned BEAT_CW = BANK_AW + 1;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_LOAD  = 4'b0010,
    ST_START = 4'b0100,
    ST_WAIT  = 4'b1000
  } state_e;

  function automatic logic [BANK_AW-1:0] bitrev9(input logic [BANK_AW-1:0] a);
    logic [BANK_AW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BANK_AW; i++) begin
      r[i] = a[BANK_AW-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/intt_load_addr_gen.sv
// Beat counter to bank select and bank address mapping.
// Macro INTT_LOAD_BITREV_EN: store the natural-order stream at bit-reversed addresses.
module intt_load_addr_gen
  import ntt_intt_pkg::*;
(
  input  logic [BEAT_CW-1:0] beat_cnt_i,
  output logic               sel_l_c_o,
  output logic               sel_r_c_o,
  output logic [BANK_AW-1:0] addr_c_o
);

  // Even beats go left, odd beats go right; the pair shares one address.
  assign sel_l_c_o = ~beat_cnt_i[0];
  assign sel_r_c_o = beat_cnt_i[0];

`ifdef INTT_LOAD_BITREV_EN
  assign addr_c_o = bitrev9(beat_cnt_i[BEAT_CW-1:1]);
`else
  assign addr_c_o = beat_cnt_i[BEAT_CW-1:1];
`endif

endmodule

// File: rtl/intt_load_ctrl.sv
// Loads one polynomial into the left/right working banks, then starts the INTT unit.
// Address order depends on INTT_LOAD_BITREV_EN (see intt_load_addr_gen).
module intt_load_ctrl
  import ntt_intt_pkg::*;
#(
  parameter int unsigned COE_WIDTH = 39,
  parameter int unsigned BEATS     = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_start,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [LANES*COE_WIDTH-1:0]   s_data,
  input  logic                         s_last,
  output logic                         o_we_l,
  output logic                         o_we_r,
  output logic [BANK_AW-1:0]           o_addr_l,
  output logic [BANK_AW-1:0]           o_addr_r,
  output logic [LANES*COE_WIDTH-1:0]   o_wdata,
  output logic                         ntt_start,
  input  logic                         ntt_done,
  output logic                         busy,
  output logic                         load_err
);

  localparam int unsigned DW = LANES * COE_WIDTH;
  localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);

  state_e             state_q, state_d;
  logic [BEAT_CW-1:0] beat_cnt_q, beat_cnt_d;
  logic               wait_mask_q, wait_mask_d;
  logic               we_l_q, we_l_d, we_r_q, we_r_d;
  logic [BANK_AW-1:0] addr_l_q, addr_l_d, addr_r_q, addr_r_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               accept_c, is_last_c, sel_l_c, sel_r_c;
  logic [BANK_AW-1:0] addr_c;

  intt_load_addr_gen u_addr_gen (
    .beat_cnt_i (beat_cnt_q),
    .sel_l_c_o  (sel_l_c),
    .sel_r_c_o  (sel_r_c),
    .addr_c_o   (addr_c)
  );

  assign s_ready   = (state_q == ST_LOAD);
  assign accept_c  = s_valid & s_ready;
  assign is_last_c = (beat_cnt_q == LAST_BEAT);

  // Next state, beat counter and write-port staging.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    wait_mask_d = 1'b0;
    we_l_d      = 1'b0;
    we_r_d      = 1'b0;
    addr_l_d    = addr_l_q;
    addr_r_d    = addr_r_q;
    wdata_d     = wdata_q;
    start_d     = (state_q == ST_START);
    err_d       = err_q;

    if (accept_c) begin
      we_l_d     = sel_l_c;
      we_r_d     = sel_r_c;
      addr_l_d   = addr_c;
      addr_r_d   = addr_c;
      wdata_d    = s_data;
      beat_cnt_d = beat_cnt_q + BEAT_CW'(1);
      if (s_last != is_last_c) err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          beat_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      ST_LOAD:  if (accept_c && is_last_c) state_d = ST_START;
      ST_START: begin
        state_d     = ST_WAIT;
        wait_mask_d = 1'b1;
      end
      // ntt_done is still high from the previous idle period during the first WAIT cycle.
      ST_WAIT:  if (ntt_done && !wait_mask_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      wait_mask_q <= 1'b0;
      we_l_q      <= 1'b0;
      we_r_q      <= 1'b0;
      addr_l_q    <= '0;
      addr_r_q    <= '0;
      wdata_q     <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      wait_mask_q <= wait_mask_d;
      we_l_q      <= we_l_d;
      we_r_q      <= we_r_d;
      addr_l_q    <= addr_l_d;
      addr_r_q    <= addr_r_d;
      wdata_q     <= wdata_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign o_we_l    = we_l_q;
  assign o_we_r    = we_r_q;
  assign o_addr_l  = addr_l_q;
  assign o_addr_r  = addr_r_q;
  assign o_wdata   = wdata_q;
  assign ntt_start = start_q;
  assign busy      = busy_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_intt_load_ctrl.sv
// Scoreboard bench for intt_load_ctrl: randomized beat streams against a reference write list.
`timescale 1ns/1ps
module tb_intt_load_ctrl;

  localparam int unsigned CW    = 39;
  localparam int unsigned BEATS = 1024;
  localparam int unsigned DW    = 4 * CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          ntt_done = 1'b1;
  logic          s_ready, o_we_l, o_we_r, ntt_start, busy, load_err;
  logic [8:0]    o_addr_l, o_addr_r;
  logic [DW-1:0] o_wdata;

  intt_load_ctrl #(.COE_WIDTH(CW), .BEATS(BEATS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .o_we_l     (o_we_l),
    .o_we_r     (o_we_r),
    .o_addr_l   (o_addr_l),
    .o_addr_r   (o_addr_r),
    .o_wdata    (o_wdata),
    .ntt_start  (ntt_start),
    .ntt_done   (ntt_done),
    .busy       (busy),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          bank_r;
    logic [8:0]    addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  n_writes = 0;
  int  n_starts = 0;
  int  last_wr_cyc = 0;
  int  last_start_cyc = 0;
  int  done_cnt = 0;
  int  done_rise_cyc = -10;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Bank address of beat k: pair index, reversed over 9 bits when the macro is on.
  function automatic logic [8:0] ref_addr(input int k);
    int v;
    int r;
    v = k / 2;
    r = 0;
`ifdef INTT_LOAD_BITREV_EN
    for (int i = 0; i < 9; i++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
`else
    r = v;
`endif
    return 9'(r);
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // INTT unit model: done drops after seeing start, rises 6160 cycles later.
  always @(posedge clk) begin
    if (ntt_start) begin
      ntt_done <= 1'b0;
      done_cnt <= 6160;
    end else if (!ntt_done) begin
      if (done_cnt <= 1) begin
        ntt_done      <= 1'b1;
        done_rise_cyc <= cyc + 1;
      end else begin
        done_cnt <= done_cnt - 1;
      end
    end
  end

  // Monitor: every bank write is popped against the reference list.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_we_l || o_we_r) begin
        wr_t e;
        n_writes++;
        last_wr_cyc = cyc;
        check("one_we", DW'(o_we_l ^ o_we_r), DW'(1));
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got write at cycle %0d expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          check("bank_sel", DW'(o_we_r), DW'(e.bank_r));
          check("addr_l", DW'(o_addr_l), DW'(e.addr));
          check("addr_r", DW'(o_addr_r), DW'(e.addr));
          check("wdata", o_wdata, e.data);
        end
      end
      if (ntt_start) begin
        n_starts++;
        last_start_cyc = cyc;
      end
      if (cyc == done_rise_cyc)     check("busy_at_done", DW'(busy), DW'(1));
      if (cyc == done_rise_cyc + 1) check("busy_drop", DW'(busy), DW'(0));
    end
  end

  task automatic run_load(input int valid_pct, input int bad_last, input bit seq_data,
                          input int abort_at, output int e0);
    int k;
    int guard;
    wr_t e;
    k = 0;
    guard = 0;
    @(negedge clk);
    load_start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    load_start = 1'b0;
    check("err_cleared", DW'(load_err), DW'(0));
    check("s_ready_load", DW'(s_ready), DW'(1));
    while (k < int'(BEATS) && guard < 20000) begin
      guard++;
      if (k == abort_at) begin
        s_valid = 1'b0;
        break;
      end
      if (int'($urandom_range(99)) < valid_pct) begin
        s_valid = 1'b1;
        s_data  = seq_data ? DW'(k) : rand_data();
        s_last  = (k == int'(BEATS) - 1) ^ (k == bad_last);
        if (s_ready) begin
          e.bank_r = k[0];
          e.addr   = ref_addr(k);
          e.data   = s_data;
          exp_q.push_back(e);
          k++;
        end
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = rand_data();
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (guard >= 20000) begin
      n_checks++;
      $display("FAIL load_timeout: got %0d beats expected %0d", k, BEATS);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", DW'(busy), DW'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, DW'(s_ready), DW'(0));
    check({tag, "_we_l"}, DW'(o_we_l), DW'(0));
    check({tag, "_we_r"}, DW'(o_we_r), DW'(0));
    check({tag, "_ntt_start"}, DW'(ntt_start), DW'(0));
    check({tag, "_busy"}, DW'(busy), DW'(0));
    check({tag, "_load_err"}, DW'(load_err), DW'(0));
    check({tag, "_addr_l"}, DW'(o_addr_l), DW'(0));
    check({tag, "_addr_r"}, DW'(o_addr_r), DW'(0));
    check({tag, "_wdata"}, o_wdata, DW'(0));
  endtask

  task automatic full_rate_seq(input string tag);
    int e0, w0, s0;
    w0 = n_writes;
    s0 = n_starts;
    run_load(100, -1, 1'b1, -1, e0);
    wait_idle();
    check({tag, "_writes"}, DW'(n_writes - w0), DW'(BEATS));
    check({tag, "_starts"}, DW'(n_starts - s0), DW'(1));
    check({tag, "_last_wr_cyc"}, DW'(last_wr_cyc), DW'(e0 + 1024));
    check({tag, "_start_cyc"}, DW'(last_start_cyc), DW'(e0 + 1025));
    check({tag, "_q_empty"}, DW'(exp_q.size()), DW'(0));
    check({tag, "_err"}, DW'(load_err), DW'(0));
  endtask

  initial begin
    int e0, w0, s0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Beats offered in IDLE are refused.
    s_valid = 1'b1;
    s_data  = rand_data();
    repeat (4) begin
      @(negedge clk);
      check("s_ready_idle", DW'(s_ready), DW'(0));
    end
    s_valid = 1'b0;
    check("idle_no_writes", DW'(n_writes), DW'(0));

    full_rate_seq("full");

    // 50% valid density, random data.
    w0 = n_writes;
    s0 = n_starts;
    run_load(50, -1, 1'b0, -1, e0);
    wait_idle();
    check("gap_writes", DW'(n_writes - w0), DW'(BEATS));
    check("gap_starts", DW'(n_starts - s0), DW'(1));
    check("gap_q_empty", DW'(exp_q.size()), DW'(0));
    check("gap_err", DW'(load_err), DW'(0));

    // Early s_last on beat 500, plus a load_start during WAIT that must be dropped.
    w0 = n_writes;
    s0 = n_starts;
    run_load(70, 500, 1'b0, -1, e0);
    repeat (10) @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("wait_busy", DW'(busy), DW'(1));
    wait_idle();
    repeat (5) @(negedge clk);
    check("no_queued_load", DW'(busy), DW'(0));
    check("early_last_err", DW'(load_err), DW'(1));
    check("early_last_writes", DW'(n_writes - w0), DW'(BEATS));
    check("early_last_starts", DW'(n_starts - s0), DW'(1));

    // Missing s_last on the final beat; run_load also checks the error clears first.
    w0 = n_writes;
    run_load(100, BEATS - 1, 1'b0, -1, e0);
    wait_idle();
    check("missing_last_err", DW'(load_err), DW'(1));
    check("missing_last_writes", DW'(n_writes - w0), DW'(BEATS));

    // Reset in the middle of a load.
    w0 = n_writes;
    s0 = n_starts;
    run_load(100, -1, 1'b1, 300, e0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    check("midrst_writes", DW'(n_writes - w0), DW'(300));
    check("midrst_q_empty", DW'(exp_q.size()), DW'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_start", DW'(n_starts - s0), DW'(0));
    check("midrst_idle", DW'(busy), DW'(0));

    full_rate_seq("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
